// File: rtl/axis_gain_ramp_controller_if.sv
// One AXI-Stream beat bundle for the gain stage.
// The master drives data/valid/last and the slave drives ready.
interface axis_gain_ramp_controller_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_gain_ramp_controller.sv
// Frame-based AXI-Stream gain stage: collect one word per channel, scale by a ramped gain
// with rounding and saturation, then retransmit the frame.
module axis_gain_ramp_controller #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_CHANNELS = 2,
  parameter int GAIN_WIDTH   = 8,
  parameter int RAMP_STEP    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GAIN_WIDTH-1:0]       target_gain,
  input  logic                        mute,
  input  logic                        clip_clear,
  output logic [GAIN_WIDTH-1:0]       current_gain,
  output logic                        clip_sticky,
  output logic                        frame_err,
  axis_gain_ramp_controller_if.slave  s_axis,
  axis_gain_ramp_controller_if.master m_axis
);
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CH_W-1:0]          CH_LAST = CH_W'(NUM_CHANNELS - 1);
  localparam logic signed [PROD_W-1:0] RND     = PROD_W'(1) << (GAIN_WIDTH - 2);
  localparam logic [GAIN_WIDTH-1:0]    STEP    = GAIN_WIDTH'(RAMP_STEP);

  typedef enum logic [1:0] {RECV, MULT, SEND} state_t;

  state_t                         state_q, state_d;
  logic [CH_W-1:0]                ch_q, ch_d, ch_inc;
  logic signed [DATA_WIDTH-1:0]   sbuf_q [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0]   sbuf_d [NUM_CHANNELS];
  logic                           s_ready_q, s_ready_d;
  logic                           m_valid_q, m_valid_d;
  logic                           m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]          m_data_q, m_data_d;
  logic [GAIN_WIDTH-1:0]          gain_q, gain_d;
  logic [GAIN_WIDTH-1:0]          eff_q, eff_d;
  logic                           clip_q, clip_d;
  logic                           ferr_q, ferr_d;
  logic                           clip_set, ferr_set;
  logic signed [PROD_W-1:0]       rounded;
  logic signed [DATA_WIDTH-1:0]   mult_res;
  logic                           mult_clip;

  // Full-precision product, then round half toward +inf by adding half an LSB before the shift.
  function automatic logic signed [PROD_W-1:0] round_prod(
    input logic signed [DATA_WIDTH-1:0] sample,
    input logic        [GAIN_WIDTH-1:0] gain
  );
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;
    s_ext = {{(PROD_W-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
    g_ext = {{(PROD_W-GAIN_WIDTH){1'b0}}, gain};
    prod  = s_ext * g_ext;
    return (prod + RND) >>> (GAIN_WIDTH - 1);
  endfunction

  function automatic logic sat_hit(input logic signed [PROD_W-1:0] r);
    logic [PROD_W-DATA_WIDTH:0] top;
    top = r[PROD_W-1:DATA_WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_val(input logic signed [PROD_W-1:0] r);
    if (!sat_hit(r)) return r[DATA_WIDTH-1:0];
    return r[PROD_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  function automatic logic [GAIN_WIDTH-1:0] ramp_gain(
    input logic [GAIN_WIDTH-1:0] cur,
    input logic [GAIN_WIDTH-1:0] eff
  );
    if (RAMP_STEP == 0) return eff;
    if (eff > cur) return ((eff - cur) > STEP) ? cur + STEP : eff;
    if (eff < cur) return ((cur - eff) > STEP) ? cur - STEP : eff;
    return cur;
  endfunction

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sbuf_d    = sbuf_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    gain_d    = gain_q;
    eff_d     = eff_q;
    clip_d    = clip_q;
    ferr_d    = ferr_q;
    clip_set  = 1'b0;
    ferr_set  = 1'b0;
    ch_inc    = ch_q + 1'b1;
    rounded   = round_prod(sbuf_q[ch_q], gain_q);
    mult_res  = sat_val(rounded);
    mult_clip = sat_hit(rounded);

    unique case (state_q)
      RECV: begin
        if (s_axis.valid && s_ready_q) begin
          sbuf_d[ch_q] = s_axis.data;
          if ((ch_q == CH_LAST) || s_axis.last) begin
            // Channels never received in a short frame must read as silence.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (i > int'(ch_q)) sbuf_d[i] = '0;
            end
            ferr_set  = (ch_q == CH_LAST) != s_axis.last;
            eff_d     = mute ? '0 : target_gain;
            state_d   = MULT;
            ch_d      = '0;
            s_ready_d = 1'b0;
          end else begin
            ch_d = ch_inc;
          end
        end
      end
      MULT: begin
        sbuf_d[ch_q] = mult_res;
        clip_set     = mult_clip;
        if (ch_q == CH_LAST) begin
          state_d   = SEND;
          ch_d      = '0;
          m_valid_d = 1'b1;
          m_data_d  = (NUM_CHANNELS == 1) ? mult_res : sbuf_q[0];
          m_last_d  = (NUM_CHANNELS == 1);
        end else begin
          ch_d = ch_inc;
        end
      end
      SEND: begin
        if (m_axis.ready) begin
          if (ch_q == CH_LAST) begin
            state_d   = RECV;
            ch_d      = '0;
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_last_d  = 1'b0;
            s_ready_d = 1'b1;
            gain_d    = ramp_gain(gain_q, eff_q);
          end else begin
            ch_d     = ch_inc;
            m_data_d = sbuf_q[ch_inc];
            m_last_d = (ch_inc == CH_LAST);
          end
        end
      end
      default: state_d = RECV;
    endcase

    // A new event in the same cycle as the clear must survive it.
    if (clip_clear) begin
      clip_d = 1'b0;
      ferr_d = 1'b0;
    end
    if (clip_set) clip_d = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RECV;
      ch_q      <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      gain_q    <= '0;
      eff_q     <= '0;
      clip_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      gain_q    <= gain_d;
      eff_q     <= eff_d;
      clip_q    <= clip_d;
      ferr_q    <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    sbuf_q <= sbuf_d;
  end

  assign s_axis.ready  = s_ready_q;
  assign m_axis.valid  = m_valid_q;
  assign m_axis.last   = m_last_q;
  assign m_axis.data   = m_data_q;
  assign current_gain  = gain_q;
  assign clip_sticky   = clip_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_axis_gain_ramp_controller.sv
// Bench for axis_gain_ramp_controller: three instances (unity-jump, ramped, four-channel)
// driven from one sequence, with a scoreboard queue per instance.
module tb_axis_gain_ramp_controller;
  localparam int DW = 16;
  localparam int GW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rst;
  logic [GW-1:0] target [3];
  logic          mute [3];
  logic          clip_clear [3];
  logic [GW-1:0] cur_gain [3];
  logic          clip_st [3];
  logic          ferr [3];
  logic [DW-1:0] s_data [3];
  logic          s_valid [3];
  logic          s_last [3];
  logic          s_ready [3];
  logic [DW-1:0] m_data [3];
  logic          m_valid [3];
  logic          m_last [3];
  logic          m_ready [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    axis_gain_ramp_controller_if #(.DATA_WIDTH(DW)) sif ();
    axis_gain_ramp_controller_if #(.DATA_WIDTH(DW)) mif ();
    assign sif.data   = s_data[k];
    assign sif.valid  = s_valid[k];
    assign sif.last   = s_last[k];
    assign s_ready[k] = sif.ready;
    assign mif.ready  = m_ready[k];
    assign m_data[k]  = mif.data;
    assign m_valid[k] = mif.valid;
    assign m_last[k]  = mif.last;

    axis_gain_ramp_controller #(
      .DATA_WIDTH  (DW),
      .NUM_CHANNELS((k == 2) ? 4 : 2),
      .GAIN_WIDTH  (GW),
      .RAMP_STEP   ((k == 1) ? 16 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst[k]),
      .target_gain (target[k]),
      .mute        (mute[k]),
      .clip_clear  (clip_clear[k]),
      .current_gain(cur_gain[k]),
      .clip_sticky (clip_st[k]),
      .frame_err   (ferr[k]),
      .s_axis      (sif),
      .m_axis      (mif)
    );
  end

  int nchk = 0;
  int nerr = 0;
  logic [DW:0] expq0[$];
  logic [DW:0] expq1[$];
  logic [DW:0] expq2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic push_exp(input int k, input logic last, input logic [DW-1:0] d);
    case (k)
      0:       expq0.push_back({last, d});
      1:       expq1.push_back({last, d});
      default: expq2.push_back({last, d});
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return expq0.size();
      1:       return expq1.size();
      default: return expq2.size();
    endcase
  endfunction

  task automatic pop_check(input int k);
    logic [DW:0] e;
    if (qsize(k) == 0) begin
      nchk++;
      nerr++;
      $display("FAIL out%0d_unexpected: got beat 0x%0h, expected none", k, m_data[k]);
      return;
    end
    case (k)
      0:       e = expq0.pop_front();
      1:       e = expq1.pop_front();
      default: e = expq2.pop_front();
    endcase
    check($sformatf("out%0d_data", k), 32'(m_data[k]), 32'(e[DW-1:0]));
    check($sformatf("out%0d_last", k), 32'(m_last[k]), 32'(e[DW]));
  endtask

  // Output beats are compared half a cycle ahead of the edge that completes them.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_valid[k] && m_ready[k] && !rst[k]) pop_check(k);
    end
  end

  task automatic send_frame(input int k, input logic [DW-1:0] w [4], input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int cnt;
      s_data[k]  = w[i];
      s_valid[k] = 1'b1;
      s_last[k]  = (i == last_at);
      hs  = 1'b0;
      cnt = 0;
      while (!hs && cnt < 200) begin
        @(negedge clk);
        hs = s_ready[k];
        @(posedge clk);
        #1;
        cnt++;
      end
      if (!hs) timeout($sformatf("in%0d_handshake", k));
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
    s_data[k]  = '0;
  endtask

  task automatic wait_idle(input int k);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while ((qsize(k) != 0 || !s_ready[k]) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 300) timeout($sformatf("idle%0d", k));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!m_valid[k] && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!m_valid[k]) timeout($sformatf("valid%0d", k));
  endtask

  task automatic pulse_clear(input int k);
    clip_clear[k] = 1'b1;
    @(posedge clk);
    #1;
    clip_clear[k] = 1'b0;
  endtask

  typedef struct {
    logic [GW-1:0] gain;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    logic [DW-1:0] out0;
    logic [DW-1:0] out1;
    logic          clip;
  } vec_t;

  initial begin
    vec_t          tbl [7];
    logic [DW-1:0] fw [4];
    logic [DW-1:0] zw [4];
    int            g;

    tbl[0] = '{8'd128, 16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 1'b0};
    tbl[1] = '{8'd64,  16'h0003, 16'hFFFD, 16'h0002, 16'hFFFF, 1'b0};
    tbl[2] = '{8'd255, 16'h7000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    tbl[3] = '{8'd128, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    tbl[4] = '{8'd0,   16'h5555, 16'hAAAA, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{8'd192, 16'h0101, 16'hFF00, 16'h0182, 16'hFE80, 1'b0};
    tbl[6] = '{8'd1,   16'h0040, 16'hFFC0, 16'h0001, 16'h0000, 1'b0};
    zw = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

    rst = 3'b111;
    for (int k = 0; k < 3; k++) begin
      target[k] = '0; mute[k] = 1'b0; clip_clear[k] = 1'b0;
      s_data[k] = '0; s_valid[k] = 1'b0; s_last[k] = 1'b0; m_ready[k] = 1'b1;
    end

    @(negedge clk);
    check("rst_s_ready",  32'(s_ready[0]),  32'd1);
    check("rst_m_valid",  32'(m_valid[0]),  32'd0);
    check("rst_m_last",   32'(m_last[0]),   32'd0);
    check("rst_m_data",   32'(m_data[0]),   32'd0);
    check("rst_gain",     32'(cur_gain[0]), 32'd0);
    check("rst_clip",     32'(clip_st[0]),  32'd0);
    check("rst_ferr",     32'(ferr[0]),     32'd0);
    check("rst_s_ready4", 32'(s_ready[2]),  32'd1);
    @(posedge clk);
    #1;
    rst = 3'b000;

    // Table: prime the gain with a silent frame, then check the scaled frame and the clip flag.
    for (int r = 0; r < 7; r++) begin
      target[0] = tbl[r].gain;
      push_exp(0, 1'b0, 16'h0000);
      push_exp(0, 1'b1, 16'h0000);
      send_frame(0, zw, 2, 1);
      wait_idle(0);
      check($sformatf("tbl%0d_gain", r), 32'(cur_gain[0]), 32'(tbl[r].gain));
      fw = '{tbl[r].in0, tbl[r].in1, 16'h0000, 16'h0000};
      push_exp(0, 1'b0, tbl[r].out0);
      push_exp(0, 1'b1, tbl[r].out1);
      send_frame(0, fw, 2, 1);
      wait_idle(0);
      check($sformatf("tbl%0d_clip", r), 32'(clip_st[0]), 32'(tbl[r].clip));
      check($sformatf("tbl%0d_ferr", r), 32'(ferr[0]), 32'd0);
      pulse_clear(0);
      check($sformatf("tbl%0d_clip_clr", r), 32'(clip_st[0]), 32'd0);
    end

    // Latency from the frame-ending handshake to the first output beat.
    target[0] = 8'd128;
    push_exp(0, 1'b0, 16'h0000);
    push_exp(0, 1'b1, 16'h0000);
    send_frame(0, zw, 2, 1);
    wait_idle(0);
    fw = '{16'h1234, 16'hEDCC, 16'h0000, 16'h0000};
    push_exp(0, 1'b0, 16'h1234);
    push_exp(0, 1'b1, 16'hEDCC);
    send_frame(0, fw, 2, 1);
    @(negedge clk);
    check("lat_t1_valid", 32'(m_valid[0]), 32'd0);
    check("lat_t1_ready", 32'(s_ready[0]), 32'd0);
    @(negedge clk);
    check("lat_t2_valid", 32'(m_valid[0]), 32'd0);
    @(negedge clk);
    check("lat_t3_valid", 32'(m_valid[0]), 32'd1);
    check("lat_t3_last",  32'(m_last[0]),  32'd0);
    @(negedge clk);
    check("lat_t4_last",  32'(m_last[0]),  32'd1);
    @(negedge clk);
    check("lat_t5_valid", 32'(m_valid[0]), 32'd0);
    check("lat_t5_data",  32'(m_data[0]),  32'd0);
    check("lat_t5_ready", 32'(s_ready[0]), 32'd1);
    wait_idle(0);

    // Final word without last still closes the frame but is flagged.
    fw = '{16'h0321, 16'h0654, 16'h0000, 16'h0000};
    push_exp(0, 1'b0, 16'h0321);
    push_exp(0, 1'b1, 16'h0654);
    send_frame(0, fw, 2, -1);
    @(negedge clk);
    check("nolast_ferr", 32'(ferr[0]), 32'd1);
    wait_idle(0);
    pulse_clear(0);
    check("nolast_ferr_clr", 32'(ferr[0]), 32'd0);

    // Ramp up by 16 per frame to 128, then mute ramps back to 0.
    target[1] = 8'd128;
    fw = '{16'h0100, 16'h0100, 16'h0000, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      g = (16 * i > 128) ? 128 : 16 * i;
      check($sformatf("ramp_up%0d_gain", i), 32'(cur_gain[1]), 32'(g));
      push_exp(1, 1'b0, DW'(2 * g));
      push_exp(1, 1'b1, DW'(2 * g));
      send_frame(1, fw, 2, 1);
      wait_idle(1);
    end
    mute[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      g = (128 - 16 * j < 0) ? 0 : 128 - 16 * j;
      check($sformatf("ramp_dn%0d_gain", j), 32'(cur_gain[1]), 32'(g));
      push_exp(1, 1'b0, DW'(2 * g));
      push_exp(1, 1'b1, DW'(2 * g));
      send_frame(1, fw, 2, 1);
      wait_idle(1);
    end

    // Four channels: backpressure hold, short frame, reset during SEND.
    target[2] = 8'd128;
    for (int i = 0; i < 4; i++) push_exp(2, i == 3, 16'h0000);
    send_frame(2, zw, 4, 3);
    wait_idle(2);
    check("c4_gain", 32'(cur_gain[2]), 32'd128);

    m_ready[2] = 1'b0;
    fw = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int i = 0; i < 4; i++) push_exp(2, i == 3, fw[i]);
    send_frame(2, fw, 4, 3);
    wait_valid(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_data", i),  32'(m_data[2]),  32'h0011);
      check($sformatf("hold%0d_valid", i), 32'(m_valid[2]), 32'd1);
      check($sformatf("hold%0d_last", i),  32'(m_last[2]),  32'd0);
      check($sformatf("hold%0d_ready", i), 32'(s_ready[2]), 32'd0);
    end
    @(posedge clk);
    #1;
    m_ready[2] = 1'b1;
    wait_idle(2);

    fw = '{16'h0100, 16'h0200, 16'h0000, 16'h0000};
    push_exp(2, 1'b0, 16'h0100);
    push_exp(2, 1'b0, 16'h0200);
    push_exp(2, 1'b0, 16'h0000);
    push_exp(2, 1'b1, 16'h0000);
    send_frame(2, fw, 2, 1);
    @(negedge clk);
    check("short_ferr", 32'(ferr[2]), 32'd1);
    wait_idle(2);
    pulse_clear(2);
    check("short_ferr_clr", 32'(ferr[2]), 32'd0);

    m_ready[2] = 1'b0;
    fw = '{16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd};
    send_frame(2, fw, 4, 3);
    wait_valid(2);
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    #1;
    check("arst_valid", 32'(m_valid[2]),  32'd0);
    check("arst_data",  32'(m_data[2]),   32'd0);
    check("arst_gain",  32'(cur_gain[2]), 32'd0);
    check("arst_ready", 32'(s_ready[2]),  32'd1);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    m_ready[2] = 1'b1;
    fw = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    for (int i = 0; i < 4; i++) push_exp(2, i == 3, 16'h0000);
    send_frame(2, fw, 4, 3);
    wait_idle(2);
    check("post_rst_gain", 32'(cur_gain[2]), 32'd128);
    for (int i = 0; i < 4; i++) push_exp(2, i == 3, 16'h0100);
    send_frame(2, fw, 4, 3);
    wait_idle(2);

    check("q0_empty", 32'(qsize(0)), 32'd0);
    check("q1_empty", 32'(qsize(1)), 32'd0);
    check("q2_empty", 32'(qsize(2)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
